id_pipe_stage: RTL

ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

---
 rtl/id_pipe_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/id_pipe_stage.sv
// ---------------------------------------------------------------------------
// id_pipe_stage -- instruction-decode pipeline stage.
//
// Holds the architectural register file, decodes the IF/ID instruction into
// register data, extended immediate and jump address, detects load-use
// hazards against a load in EX, and registers the decoded bundle into ID/EX.
//
// Optional feature macro: ID_BRANCH_RESOLVE_EN
//   defined   -> beq/bne resolved in ID, drives o_branch_taken/o_branch_target
//   undefined -> o_branch_taken/o_branch_target tied to 0, no comparator
//
// Ports
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_step                global advance enable (0 = all state holds)
//   i_valid/i_instr/i_pc4 IF/ID instruction
//   i_flush               kill the instruction in ID (bubble)
//   i_extension_mode      immediate extension mode
//   i_mem_wb_regwrite,
//   i_wb_dir_rd,
//   i_wb_write            writeback port
//   i_ex_memread,
//   i_ex_dir_rt           load in EX (hazard source)
//   i_tx_dir_debug,
//   o_data_tx_debug       combinational debug read (no writeback bypass)
//   o_stall               combinational load-use stall request to IF
//   o_valid .. o_dir_rd   registered ID/EX bundle
//   o_branch_taken/target combinational branch redirect
// ---------------------------------------------------------------------------
module id_pipe_stage #(
    parameter int BITS_SIZE      = 32,
    parameter int BITS_REGS      = 5,
    parameter int BITS_JUMP      = 26,
    parameter int BITS_INMEDIATE = 16,
    parameter int BITS_EXTENSION = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_step,
    input  logic                      i_valid,
    input  logic [BITS_SIZE-1:0]      i_instr,
    input  logic [BITS_SIZE-1:0]      i_pc4,
    input  logic                      i_flush,
    input  logic [BITS_EXTENSION-1:0] i_extension_mode,
    input  logic                      i_mem_wb_regwrite,
    input  logic [BITS_REGS-1:0]      i_wb_dir_rd,
    input  logic [BITS_SIZE-1:0]      i_wb_write,
    input  logic                      i_ex_memread,
    input  logic [BITS_REGS-1:0]      i_ex_dir_rt,
    input  logic [BITS_REGS-1:0]      i_tx_dir_debug,
    output logic [BITS_SIZE-1:0]      o_data_tx_debug,
    output logic                      o_stall,
    output logic                      o_valid,
    output logic [BITS_SIZE-1:0]      o_data_rs,
    output logic [BITS_SIZE-1:0]      o_data_rt,
    output logic [BITS_SIZE-1:0]      o_extensionresult,
    output logic [BITS_SIZE-1:0]      o_jump_addr,
    output logic [BITS_SIZE-1:0]      o_pc4,
    output logic [BITS_REGS-1:0]      o_dir_rs,
    output logic [BITS_REGS-1:0]      o_dir_rt,
    output logic [BITS_REGS-1:0]      o_dir_rd,
    output logic                      o_branch_taken,
    output logic [BITS_SIZE-1:0]      o_branch_target
);

    localparam int NUM_REGS = 2 ** BITS_REGS;
    localparam int EXT_PAD  = BITS_SIZE - BITS_INMEDIATE;

    typedef struct packed {
        logic                 valid;
        logic [BITS_SIZE-1:0] data_rs;
        logic [BITS_SIZE-1:0] data_rt;
        logic [BITS_SIZE-1:0] ext;
        logic [BITS_SIZE-1:0] jump;
        logic [BITS_SIZE-1:0] pc4;
        logic [BITS_REGS-1:0] dir_rs;
        logic [BITS_REGS-1:0] dir_rt;
        logic [BITS_REGS-1:0] dir_rd;
    } bundle_t;

    logic [BITS_SIZE-1:0]      regs_q [NUM_REGS];
    bundle_t                   bundle_q, bundle_d;

    logic [BITS_REGS-1:0]      dir_rs, dir_rt, dir_rd;
    logic [BITS_INMEDIATE-1:0] imm;
    logic [BITS_SIZE-1:0]      imm_sext, imm_sext_sh2, ext_result;
    logic [BITS_SIZE-1:0]      data_rs, data_rt, jump_addr;
    logic                      wr_en;

    assign dir_rs = i_instr[21 +: BITS_REGS];
    assign dir_rt = i_instr[16 +: BITS_REGS];
    assign dir_rd = i_instr[11 +: BITS_REGS];
    assign imm    = i_instr[BITS_INMEDIATE-1:0];

    assign wr_en  = i_step && i_mem_wb_regwrite && (i_wb_dir_rd != '0);

    // Register 0 is never written, so it always reads back as zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[i_wb_dir_rd] <= i_wb_write;
        end
    end

    // Write-before-read: a writeback landing this cycle is visible to decode.
    always_comb begin
        data_rs = regs_q[dir_rs];
        data_rt = regs_q[dir_rt];
        if (i_mem_wb_regwrite && i_wb_dir_rd != '0 && i_wb_dir_rd == dir_rs) begin
            data_rs = i_wb_write;
        end
        if (i_mem_wb_regwrite && i_wb_dir_rd != '0 && i_wb_dir_rd == dir_rt) begin
            data_rt = i_wb_write;
        end
    end

    assign o_data_tx_debug = regs_q[i_tx_dir_debug];

    assign imm_sext     = {{EXT_PAD{imm[BITS_INMEDIATE-1]}}, imm};
    assign imm_sext_sh2 = {imm_sext[BITS_SIZE-3:0], 2'b00};

    always_comb begin
        ext_result = imm_sext;
        case (i_extension_mode)
            2'b01:   ext_result = {{EXT_PAD{1'b0}}, imm};
            2'b10:   ext_result = {imm, {EXT_PAD{1'b0}}};
            2'b11:   ext_result = imm_sext_sh2;
            default: ext_result = imm_sext;
        endcase
    end

    assign jump_addr = {i_pc4[BITS_SIZE-1 -: 4], i_instr[BITS_JUMP-1:0], 2'b00};

    assign o_stall = i_valid && i_ex_memread && (i_ex_dir_rt != '0) &&
                     ((i_ex_dir_rt == dir_rs) || (i_ex_dir_rt == dir_rt));

    always_comb begin
        bundle_d = bundle_q;
        if (i_step) begin
            if (i_flush || o_stall) begin
                bundle_d = '0;
            end else begin
                bundle_d.valid   = i_valid;
                bundle_d.data_rs = data_rs;
                bundle_d.data_rt = data_rt;
                bundle_d.ext     = ext_result;
                bundle_d.jump    = jump_addr;
                bundle_d.pc4     = i_pc4;
                bundle_d.dir_rs  = dir_rs;
                bundle_d.dir_rt  = dir_rt;
                bundle_d.dir_rd  = dir_rd;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign o_valid           = bundle_q.valid;
    assign o_data_rs         = bundle_q.data_rs;
    assign o_data_rt         = bundle_q.data_rt;
    assign o_extensionresult = bundle_q.ext;
    assign o_jump_addr       = bundle_q.jump;
    assign o_pc4             = bundle_q.pc4;
    assign o_dir_rs          = bundle_q.dir_rs;
    assign o_dir_rt          = bundle_q.dir_rt;
    assign o_dir_rd          = bundle_q.dir_rd;

`ifdef ID_BRANCH_RESOLVE_EN
    logic [5:0] opcode;
    logic       rs_eq_rt;

    assign opcode   = i_instr[BITS_SIZE-1 -: 6];
    assign rs_eq_rt = (data_rs == data_rt);

    always_comb begin
        o_branch_taken = 1'b0;
        if (i_valid && !o_stall && !i_flush) begin
            case (opcode)
                6'b000100: o_branch_taken = rs_eq_rt;
                6'b000101: o_branch_taken = !rs_eq_rt;
                default:   o_branch_taken = 1'b0;
            endcase
        end
    end

    assign o_branch_target = i_pc4 + imm_sext_sh2;
`else
    logic unused_opcode;

    assign unused_opcode   = ^i_instr[BITS_SIZE-1:BITS_JUMP];
    assign o_branch_taken  = 1'b0;
    assign o_branch_target = '0;
`endif

endmodule
